// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and RISCV_32 default widths for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

    localparam int RV32_ADDR_W = 32;
    localparam int RV32_DATA_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RESP_F = 2'd1;
    localparam logic [1:0] ST_RESP_D = 2'd2;

    // Owner of the read data returning from memory in the current cycle.
    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        RESP_F = ST_RESP_F,
        RESP_D = ST_RESP_D
    } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data grant selection: data has priority until fetch has waited STARVE_MAX data grants.
module mem_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          fetch_due;

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        fetch_due = (starve_cnt == CNT_MAX);
        if_gnt    = rst_n && if_req && (!d_req || fetch_due);
        d_gnt     = rst_n && d_req && !if_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && !fetch_due) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by instruction fetch and load/store; one grant per cycle, response one cycle later.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = RV32_ADDR_W,
    parameter int DATA_W     = RV32_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          dbg_state
);

    // Handshake: a requester holds req and its fields until the cycle gnt is high;
    // that cycle is the transfer, and rvalid returns exactly one cycle later.
    owner_e state_q, state_d;
    logic   store_q;

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk   (clk),
        .rst_n (rst_n),
        .if_req(if_req),
        .d_req (d_req),
        .if_gnt(if_gnt),
        .d_gnt (d_gnt)
    );

    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        state_d   = IDLE;
        if (if_gnt) begin
            mem_be   = '1;
            mem_addr = if_addr;
            state_d  = RESP_F;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            state_d   = RESP_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= d_gnt && d_we;
        end
    end

    // A store acknowledge carries no data, so the memory bus is masked off.
    assign if_rvalid = (state_q == RESP_F);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rvalid  = (state_q == RESP_D);
    assign d_rdata   = (d_rvalid && !store_q) ? mem_rdata : '0;
    assign dbg_state = state_q;

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, default 4, consecutive data grants allowed while fetch waits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 if_req  input  1  instruction-fetch read request; held with if_addr until if_gnt.
REQ-007 if_addr  input  ADDR_W  fetch byte address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  fetch read data valid.
REQ-010 if_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  load/store request; held with d_we/d_be/d_addr/d_wdata until d_gnt.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_be  input  DATA_W/8  store byte enables.
REQ-014 d_addr  input  ADDR_W  data byte address.
REQ-015 d_wdata  input  DATA_W  store data.
REQ-016 d_gnt  output  1  data request accepted this cycle.
REQ-017 d_rvalid  output  1  load data valid, or store acknowledge.
REQ-018 d_rdata  output  DATA_W  load data; all zeros for a store acknowledge.
REQ-019 mem_en, mem_we  output  1 each  single-port memory enable and write strobe.
REQ-020 mem_be  output  DATA_W/8; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  memory command fields.
REQ-021 mem_rdata  input  DATA_W  memory read data, valid exactly one cycle after a mem_en cycle.

Function
REQ-022 At most one grant per cycle; a grant is combinational from the current requests and state, with zero-cycle grant latency.
REQ-023 In a granted cycle, mem_en = 1 and the mem_* fields are driven from the winning requester; a fetch grant drives mem_we = 0 and mem_be = all ones.
REQ-024 Arbitration: only one request present -> it wins; both present -> data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-025 starve_cnt increments on each data grant made while if_req = 1; it clears on any fetch grant or in any cycle where if_req = 0; it saturates at STARVE_MAX.
REQ-026 Owner FSM states: IDLE, RESP_F, RESP_D; next state is RESP_F on a fetch grant, RESP_D on a data grant, and IDLE otherwise. Every state permits a new grant in the same cycle.
REQ-027 Response timing: in RESP_F, if_rvalid = 1 and if_rdata = mem_rdata; in RESP_D, d_rvalid = 1 and d_rdata = mem_rdata for a load or 0 for a store.
REQ-028 The store flag of an accepted data request is registered alongside the owner state.
REQ-029 Response latency is exactly one cycle after the grant; back-to-back grants give back-to-back responses.
REQ-030 A requester with req = 0 is never granted, and rvalid is never asserted for a requester that was not granted in the previous cycle.
REQ-031 Outside the response states, if_rdata and d_rdata are 0.

Reset
REQ-032 While rst_n = 0: FSM = IDLE, starve_cnt = 0, store flag = 0, all gnt/rvalid = 0, mem_en = 0, mem_we = 0.
REQ-033 Reset asserted with a response pending drops that response; no rvalid appears after reset release.
REQ-034 The first grant is possible in the first rising edge cycle after rst_n deasserts.

Structure
REQ-035 A shared package holds the owner-state enum (IDLE/RESP_F/RESP_D) and the default ADDR_W/DATA_W constants used by the RISCV_32 core.
REQ-036 The grant/starvation logic is one sub-module, mem_arb_prio (combinational priority plus starve_cnt register); the top holds the owner FSM and muxing.

Verification
REQ-037 Fetch only: if_req with if_addr 0x00, 0x04, 0x08 on consecutive cycles -> if_gnt each cycle, if_rvalid on the following three cycles with memory contents, d_* idle.
REQ-038 Collision: if_req and d_req (load 0x100) in the same cycle -> d_gnt first, if_gnt next cycle, d_rvalid and if_rvalid one cycle after their respective grants.
REQ-039 Starvation: d_req held for 10 cycles with if_req held -> exactly 4 d_gnt, then 1 if_gnt, then pattern repeats.
REQ-040 Store: d_we = 1, d_be = 4'b0011, d_addr 0x200, d_wdata 0xAABBCCDD -> mem_we = 1 with identical fields, d_rvalid next cycle with d_rdata = 0; a later load of 0x200 returns only the low two bytes updated.
REQ-041 Reset mid-operation: rst_n pulled low in the cycle after a grant -> no rvalid, all outputs 0; after release, a single fetch request is granted immediately.
